// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg
//   Shared definitions for the RV32M divide/remainder engine:
//   funct3 opcodes, rd address width, FSM state type and opcode decode helpers.
package ex_div_unit_pkg;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_START = 2'd1,
    DIV_CALC  = 2'd2,
    DIV_END   = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return !((op == INST_DIV) || (op == INST_DIVU));
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// ex_div_unit_if
//   Request/response bundle between execute (master) and the divider (slave).
//   start_i/dividend_i/divisor_i/op_i/reg_waddr_i/flush_i : request from execute
//   busy_o/ready_o/result_o/reg_waddr_o                   : response to execute/ctrl
interface ex_div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  import ex_div_unit_pkg::*;

  logic                  start_i;
  logic [DATA_W-1:0]     dividend_i;
  logic [DATA_W-1:0]     divisor_i;
  logic [2:0]            op_i;
  logic [REG_ADDR_W-1:0] reg_waddr_i;
  logic                  flush_i;
  logic                  busy_o;
  logic                  ready_o;
  logic [DATA_W-1:0]     result_o;
  logic [REG_ADDR_W-1:0] reg_waddr_o;

  modport master (
    output start_i, dividend_i, divisor_i, op_i, reg_waddr_i, flush_i,
    input  busy_o, ready_o, result_o, reg_waddr_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i, op_i, reg_waddr_i, flush_i,
    output busy_o, ready_o, result_o, reg_waddr_o
  );

endinterface

// File: rtl/ex_div_step.sv
// ex_div_step
//   One combinational radix-2 restoring iteration.
//   rem_i/dvd_i : partial remainder and dividend shift register (quotient bits fill the LSBs)
//   divisor_i   : divisor magnitude
//   rem_o/dvd_o : next remainder and shifted dividend (LSB left 0, caller inserts qbit_o)
//   qbit_o      : quotient bit produced this iteration
module ex_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dvd_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dvd_o,
  output logic              qbit_o
);

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;

  always_comb begin
    trial  = {rem_i, dvd_i[DATA_W-1]};
    qbit_o = (trial >= {1'b0, divisor_i});
    // When the subtraction is taken the true difference is below the divisor,
    // so the low DATA_W bits carry it exactly.
    diff   = trial[DATA_W-1:0] - divisor_i;
    rem_o  = qbit_o ? diff : trial[DATA_W-1:0];
    dvd_o  = {dvd_i[DATA_W-2:0], 1'b0};
  end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit
//   Multi-cycle RV32M DIV/DIVU/REM/REMU engine, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ex_div_unit_if.slave (request from execute, busy/ready/result back)
//   Optional: define DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  ex_div_unit_if.slave   bus
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e            state;
  logic [2:0]            op_r;
  logic [DATA_W-1:0]     dvd_raw;
  logic [DATA_W-1:0]     dsr_raw;
  logic [DATA_W-1:0]     dvd;
  logic [DATA_W-1:0]     rem;
  logic [CNT_W-1:0]      count;
  logic [REG_ADDR_W-1:0] waddr_r;

  logic              dvd_neg;
  logic              dsr_neg;
  logic              div_zero;
  logic              early_out;
  logic              ready;
  logic [DATA_W-1:0] dvd_abs;
  logic [DATA_W-1:0] dsr_abs;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_dvd;
  logic              step_qbit;

  // Operands are held raw; magnitudes and sign fix-up are derived from them.
  always_comb begin
    dvd_neg  = op_is_signed(op_r) & dvd_raw[DATA_W-1];
    dsr_neg  = op_is_signed(op_r) & dsr_raw[DATA_W-1];
    dvd_abs  = dvd_neg ? -dvd_raw : dvd_raw;
    dsr_abs  = dsr_neg ? -dsr_raw : dsr_raw;
    div_zero = (dsr_raw == '0);
`ifdef DIV_EARLY_OUT_EN
    early_out = (dvd_abs < dsr_abs);
`else
    early_out = 1'b0;
`endif
    quot_fix = (dvd_neg ^ dsr_neg) ? -dvd : dvd;
    rem_fix  = dvd_neg ? -rem : rem;
    if (div_zero) begin
      quot_fix = '1;
      rem_fix  = dvd_raw;
    end
    result = op_is_rem(op_r) ? rem_fix : quot_fix;
  end

  ex_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem),
    .dvd_i     (dvd),
    .divisor_i (dsr_abs),
    .rem_o     (step_rem),
    .dvd_o     (step_dvd),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= DIV_IDLE;
      op_r    <= '0;
      dvd_raw <= '0;
      dsr_raw <= '0;
      dvd     <= '0;
      rem     <= '0;
      count   <= '0;
      waddr_r <= '0;
    end else if (bus.flush_i) begin
      state <= DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (bus.start_i) begin
            op_r    <= bus.op_i;
            dvd_raw <= bus.dividend_i;
            dsr_raw <= bus.divisor_i;
            waddr_r <= bus.reg_waddr_i;
            state   <= DIV_START;
          end
        end
        DIV_START: begin
          count <= '0;
          if (div_zero) begin
            state <= DIV_END;
          end else if (early_out) begin
            // Quotient 0, remainder magnitude = dividend magnitude; the END
            // fix-up restores the dividend's sign.
            dvd   <= '0;
            rem   <= dvd_abs;
            state <= DIV_END;
          end else begin
            dvd   <= dvd_abs;
            rem   <= '0;
            state <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          dvd   <= step_dvd | DATA_W'(step_qbit);
          rem   <= step_rem;
          count <= count + 1'b1;
          if (count == CNT_LAST) state <= DIV_END;
        end
        DIV_END: state <= DIV_IDLE;
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // A flush arriving in the END cycle must still suppress the result pulse.
  always_comb begin
    ready           = (state == DIV_END) && !bus.flush_i;
    bus.ready_o     = ready;
    bus.busy_o      = (state == DIV_START) || (state == DIV_CALC);
    bus.result_o    = ready ? result : '0;
    bus.reg_waddr_o = waddr_r;
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit
//   Directed bench for ex_div_unit: a cycle-level reference model (plain 64-bit
//   arithmetic plus a latency rule) is compared against busy/ready/result/rd every
//   cycle, and each directed operation is also pinned to hand-computed literals.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_div_unit_if #(.DATA_W(W)) bus ();
  ex_div_unit #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic longint sval(input logic [31:0] v, input bit sgn);
    if (sgn) return longint'($signed(v));
    return longint'({32'b0, v});
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit          sgn;
    bit          is_rem;
    longint      sa;
    longint      sb;
    logic [63:0] v;
    sgn    = (op == INST_DIV) || (op == INST_REM);
    is_rem = (op == INST_REM) || (op == INST_REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    sa = sval(a, sgn);
    sb = sval(b, sgn);
    v  = is_rem ? 64'(sa % sb) : 64'(sa / sb);
    return v[31:0];
  endfunction

  // Edges from the start-sampling edge until ready_o is shown.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit     sgn;
    longint ma;
    longint mb;
    sgn = (op == INST_DIV) || (op == INST_REM);
    ma  = sval(a, sgn);
    mb  = sval(b, sgn);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return W + 1;
  endfunction

  // Reference model state
  int          cyc = 0;
  bit          m_pend = 1'b0;
  int          m_ready_at = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= 1'b0;
      m_rd   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (bus.flush_i) begin
        m_pend <= 1'b0;
      end else if (m_pend) begin
        if (cyc + 1 == m_ready_at + 1) m_pend <= 1'b0;
      end else if (bus.start_i) begin
        m_pend     <= 1'b1;
        m_ready_at <= cyc + 1 + ref_latency(bus.op_i, bus.dividend_i, bus.divisor_i);
        m_res      <= ref_result(bus.op_i, bus.dividend_i, bus.divisor_i);
        m_rd       <= bus.reg_waddr_i;
      end
    end
  end

  // Per-cycle compare
  always begin
    logic e_ready;
    logic e_busy;
    @(negedge clk);
    #1;
    e_ready = m_pend && (cyc == m_ready_at) && !bus.flush_i;
    e_busy  = m_pend && (cyc < m_ready_at);
    check("cyc_busy",  32'(bus.busy_o),  32'(e_busy));
    check("cyc_ready", 32'(bus.ready_o), 32'(e_ready));
    check("cyc_result", bus.result_o, e_ready ? m_res : 32'd0);
    check("cyc_rd", 32'(bus.reg_waddr_o), 32'(m_rd));
  end

  task automatic wait_ready(input int max_cyc, output bit seen, output int n,
                            output logic [31:0] res, output logic [4:0] rd);
    seen = 1'b0;
    n    = 0;
    res  = '0;
    rd   = '0;
    for (int i = 1; i <= max_cyc && !seen; i++) begin
      if (i > 1) @(negedge clk);
      #2;
      if (bus.ready_o) begin
        seen = 1'b1;
        n    = i;
        res  = bus.result_o;
        rd   = bus.reg_waddr_o;
      end
    end
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = rd;
    @(negedge clk);
    bus.start_i     = 1'b0;
    bus.dividend_i  = ~a;
    bus.divisor_i   = ~b;
    bus.reg_waddr_i = ~rd;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    bit          seen;
    int          n;
    logic [31:0] res;
    logic [4:0]  got_rd;
    launch(op, a, b, rd);
    wait_ready(60, seen, n, res, got_rd);
    check({name, "_seen"},    32'(seen), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_result"},  res, exp_res);
    check({name, "_rd"},      32'(got_rd), 32'(rd));
  endtask

  task automatic expect_quiet(input string name, input int ncyc);
    bit any;
    any = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      #2;
      if (bus.ready_o) any = 1'b1;
    end
    check(name, 32'(any), 32'd0);
  endtask

  int early_lat;

  initial begin
    bit          seen;
    int          n;
    logic [31:0] res;
    logic [4:0]  got_rd;

`ifdef DIV_EARLY_OUT_EN
    early_lat = 2;
`else
    early_lat = 34;
`endif
    bus.start_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.op_i        = '0;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.reg_waddr_i = '0;

    // Pin the reference model to hand-computed values.
    check("model_div_neg",  ref_result(INST_DIV, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
    check("model_rem_neg",  ref_result(INST_REM, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    check("model_div_ovf",  ref_result(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_divu_zero", ref_result(INST_DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    check("reset_busy",   32'(bus.busy_o), 32'd0);
    check("reset_ready",  32'(bus.ready_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    check("reset_rd",     32'(bus.reg_waddr_o), 32'd0);

    run_op("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op("remu_100_7", INST_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 34);
    run_op("div_m20_3",  INST_DIV,  32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFA, 34);
    run_op("rem_m20_3",  INST_REM,  32'hFFFF_FFEC, 32'd3, 5'd11, 32'hFFFF_FFFE, 34);
    run_op("rem_20_m3",  INST_REM,  32'd20, 32'hFFFF_FFFD, 5'd12, 32'd2, 34);
    run_op("div_7_m2",   INST_DIV,  32'd7, 32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34);
    run_op("divu_5_0",   INST_DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 2);
    run_op("rem_m5_0",   INST_REM,  32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFB, 2);
    run_op("div_ovf",    INST_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 34);
    run_op("rem_ovf",    INST_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 34);
    run_op("divu_max_1", INST_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd18, 32'hFFFF_FFFF, 34);
    run_op("remu_max_10", INST_REMU, 32'hFFFF_FFFF, 32'd10, 5'd19, 32'd5, 34);
    run_op("divu_3_9",   INST_DIVU, 32'd3, 32'd9, 5'd20, 32'd0, early_lat);
    run_op("remu_3_9",   INST_REMU, 32'd3, 32'd9, 5'd21, 32'd3, early_lat);
    run_op("rem_m3_9",   INST_REM,  32'hFFFF_FFFD, 32'd9, 5'd22, 32'hFFFF_FFFD, early_lat);

    // Flush in the 10th CALC cycle (START is the first cycle after launch).
    launch(INST_DIVU, 32'd1000, 32'd3, 5'd9);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #2;
    check("flush_busy_low", 32'(bus.busy_o), 32'd0);
    expect_quiet("flush_no_ready", 40);
    run_op("after_flush", INST_DIVU, 32'd1000, 32'd3, 5'd9, 32'd333, 34);

    // start and flush together in IDLE: nothing launches.
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.flush_i   = 1'b1;
    bus.op_i      = INST_DIVU;
    bus.dividend_i = 32'd8;
    bus.divisor_i = 32'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #2;
    check("flush_start_busy", 32'(bus.busy_o), 32'd0);
    expect_quiet("flush_start_no_ready", 5);

    // start while busy is ignored.
    launch(INST_DIVU, 32'd50, 32'd5, 5'd3);
    repeat (4) @(negedge clk);
    bus.start_i     = 1'b1;
    bus.op_i        = INST_REMU;
    bus.dividend_i  = 32'd77;
    bus.divisor_i   = 32'd2;
    bus.reg_waddr_i = 5'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_ready(60, seen, n, res, got_rd);
    check("busy_start_seen",   32'(seen), 32'd1);
    check("busy_start_result", res, 32'd10);
    check("busy_start_rd",     32'(got_rd), 32'd3);
    expect_quiet("busy_start_no_second", 40);

    // Async reset in the middle of CALC.
    launch(INST_DIVU, 32'd100, 32'd7, 5'd7);
    repeat (10) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy_o), 32'd0);
    check("midrst_ready",  32'(bus.ready_o), 32'd0);
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_rd",     32'(bus.reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("midrst_no_ready", 40);
    run_op("after_reset", INST_DIV, 32'hFFFF_FF9C, 32'd7, 5'd1, 32'hFFFF_FFF2, 34);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
